video_sync_analyzer: RTL and testbench

// - Sink-side consumer of a VIDEO_IF.IN stream. Measures incoming raster timing (line/frame

---
 rtl/video_sync_analyzer.sv | 167 ++++++++++++++++
 tb/tb_video_sync_analyzer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_analyzer.sv
// video_sync_analyzer: measures raster timing and reports lock and mode changes; define VIDEO_ANALYZER_CRC_EN to build the per-frame pixel CRC
module video_sync_analyzer #(
  parameter int HW = 12,
  parameter int VW = 11,
  parameter int LOCK_FRAMES = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dclk_i,
  input  logic          hs_n_i,
  input  logic          vs_n_i,
  input  logic [7:0]    r_i,
  input  logic [7:0]    g_i,
  input  logic [7:0]    b_i,
  output logic [HW-1:0] h_total_o,
  output logic [HW-1:0] h_sync_o,
  output logic [VW-1:0] v_total_o,
  output logic [VW-1:0] v_sync_o,
  output logic          frame_start_o,
  output logic          locked_o,
  output logic          mode_change_o,
  output logic [15:0]   frame_crc_o
);
  localparam int MW = $clog2(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;
  state_t state_q;
  logic hs_prev_q, vs_prev_q, line_started_q, ref_valid_q, bad_q, first_q, prev_ok_q;
  logic [HW-1:0] h_cnt_q, hs_w_q, ref_len_q, h_total_q, h_sync_q;
  logic [VW-1:0] v_cnt_q, vs_w_q, v_total_q, v_sync_q;
  logic [VW:0] wd_q;
  logic [MW-1:0] match_q, match_nx;
  logic frame_start_q, locked_q, mc_q;
  logic hs_fall, hs_rise, close, h_max, v_max, full_line, ref_set, len_bad, bad_cur, good_same, trip;
  logic [HW-1:0] h_inc, ref_cur;
  logic [VW-1:0] v_cur, vs_cur;
  assign hs_fall   = dclk_i & hs_prev_q & ~hs_n_i;
  assign hs_rise   = dclk_i & ~hs_prev_q & hs_n_i;
  assign close     = dclk_i & vs_prev_q & ~vs_n_i;
  assign h_max     = &h_cnt_q;
  assign v_max     = &v_cnt_q;
  assign h_inc     = h_cnt_q + 1'b1;
  assign full_line = hs_fall & line_started_q;
  assign ref_set   = full_line & ~ref_valid_q;
  assign ref_cur   = ref_set ? h_inc : ref_len_q;
  assign len_bad   = full_line & ref_valid_q & (h_inc != ref_len_q);
  assign v_cur     = (hs_fall & ~v_max) ? v_cnt_q + 1'b1 : v_cnt_q;
  assign vs_cur    = (hs_fall & ~vs_n_i & ~(&vs_w_q)) ? vs_w_q + 1'b1 : vs_w_q;
  assign bad_cur   = bad_q | len_bad | (dclk_i & h_max) | (hs_fall & v_max) | first_q;
  assign good_same = ~bad_cur & (ref_cur == h_total_q) & (v_cur == v_total_q);
  assign match_nx  = match_q + 1'b1;
  assign trip      = ~close & (wd_q[VW] | (dclk_i & h_max & ~hs_fall));
  // raster counters and frame-close snapshot of the measurements
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_prev_q      <= 1'b1;
      vs_prev_q      <= 1'b1;
      h_cnt_q        <= '0;
      hs_w_q         <= '0;
      line_started_q <= 1'b0;
      ref_len_q      <= '0;
      ref_valid_q    <= 1'b0;
      v_cnt_q        <= '0;
      vs_w_q         <= '0;
      bad_q          <= 1'b0;
      first_q        <= 1'b1;
      wd_q           <= '0;
      frame_start_q  <= 1'b0;
      h_total_q      <= '0;
      h_sync_q       <= '0;
      v_total_q      <= '0;
      v_sync_q       <= '0;
    end else begin
      if (dclk_i) begin
        hs_prev_q <= hs_n_i;
        vs_prev_q <= vs_n_i;
        h_cnt_q   <= hs_fall ? '0 : (h_max ? h_cnt_q : h_inc);
      end
      if (hs_fall) line_started_q <= 1'b1;
      if (hs_rise) hs_w_q <= h_inc;
      ref_len_q     <= ref_cur;
      ref_valid_q   <= close ? 1'b0 : (ref_valid_q | ref_set);
      v_cnt_q       <= close ? '0 : v_cur;
      vs_w_q        <= close ? '0 : vs_cur;
      bad_q         <= close ? 1'b0 : bad_cur;
      first_q       <= close ? 1'b0 : first_q;
      wd_q          <= close ? '0 : ((hs_fall & ~wd_q[VW]) ? wd_q + 1'b1 : wd_q);
      frame_start_q <= close;
      if (close) begin
        h_total_q <= ref_cur;
        h_sync_q  <= hs_w_q;
        v_total_q <= v_cur;
        v_sync_q  <= vs_cur;
      end
    end
  end
  // lock tracking, evaluated at each frame close, with the watchdog forcing a fresh search
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      match_q   <= '0;
      prev_ok_q <= 1'b0;
      locked_q  <= 1'b0;
      mc_q      <= 1'b0;
    end else begin
      mc_q <= 1'b0;
      if (close) begin
        prev_ok_q <= ~bad_cur;
        case (state_q)
          SEARCH: begin
            state_q <= TRACK;
            match_q <= '0;
          end
          TRACK: begin
            match_q <= (good_same & prev_ok_q) ? match_nx : '0;
            if (good_same & prev_ok_q & (match_nx == MW'(LOCK_FRAMES - 1))) begin
              state_q  <= LOCK;
              locked_q <= 1'b1;
            end
          end
          default: if (!good_same) begin
            state_q  <= TRACK;
            locked_q <= 1'b0;
            mc_q     <= 1'b1;
            match_q  <= '0;
          end
        endcase
      end else if (trip) begin
        state_q  <= SEARCH;
        locked_q <= 1'b0;
        mc_q     <= locked_q;
        match_q  <= '0;
      end
    end
  end
`ifdef VIDEO_ANALYZER_CRC_EN
  logic [15:0] crc_q, crc_nx, frame_crc_q;
  logic [23:0] px;
  assign px = {r_i, g_i, b_i};
  // CRC-16-CCITT over the 24 pixel bits, MSB first
  always_comb begin
    crc_nx = crc_q;
    for (int i = 23; i >= 0; i--) crc_nx = {crc_nx[14:0], 1'b0} ^ ((crc_nx[15] ^ px[i]) ? 16'h1021 : 16'h0000);
  end
  // accumulate active pixels, publish and reseed at frame close
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= close ? 16'hFFFF : ((dclk_i & hs_n_i & vs_n_i) ? crc_nx : crc_q);
      frame_crc_q <= close ? crc_q : frame_crc_q;
    end
  end
  assign frame_crc_o = frame_crc_q;
`else
  logic unused_rgb;
  assign unused_rgb  = ^{r_i, g_i, b_i};
  assign frame_crc_o = 16'h0000;
`endif
  assign h_total_o     = h_total_q;
  assign h_sync_o      = h_sync_q;
  assign v_total_o     = v_total_q;
  assign v_sync_o      = v_sync_q;
  assign frame_start_o = frame_start_q;
  assign locked_o      = locked_q;
  assign mode_change_o = mc_q;
endmodule

// File: tb/tb_video_sync_analyzer.sv
// tb_video_sync_analyzer: directed raster scenarios for video_sync_analyzer on scaled-down timings
module tb_video_sync_analyzer;
  localparam int HW = 8;
  localparam int VW = 6;
  logic clk = 1'b0, rst = 1'b1, dclk = 1'b0, hs_n = 1'b1, vs_n = 1'b1;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [HW-1:0] h_total, h_sync;
  logic [VW-1:0] v_total, v_sync;
  logic frame_start, locked, mode_change;
  logic [15:0] frame_crc;
  int checks = 0, errors = 0, fs_cnt = 0, mc_cnt = 0;
  int div = 1, ght = 24, ghs = 4, gvt = 16, gvs = 2;
  logic mp_vs = 1'b1;
  logic [15:0] m_acc = 16'hFFFF, m_crc = 16'h0000;

  video_sync_analyzer #(.HW(HW), .VW(VW), .LOCK_FRAMES(3)) dut (
    .clk_i(clk), .rst_i(rst), .dclk_i(dclk), .hs_n_i(hs_n), .vs_n_i(vs_n),
    .r_i(r), .g_i(g), .b_i(b),
    .h_total_o(h_total), .h_sync_o(h_sync), .v_total_o(v_total), .v_sync_o(v_sync),
    .frame_start_o(frame_start), .locked_o(locked), .mode_change_o(mode_change),
    .frame_crc_o(frame_crc));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (mode_change) mc_cnt++;
  end

  typedef struct {
    int div, ht, hsw, vt, vsw, nfr, lk;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    for (int i = 23; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dclk = 1'b0;
    hs_n = 1'b1;
    vs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mp_vs = 1'b1;
    m_acc = 16'hFFFF;
    m_crc = 16'h0000;
    @(negedge clk);
  endtask

  task automatic pix(input logic h, input logic v, input logic [7:0] p);
    logic cl;
    cl = mp_vs & ~v;
    dclk = 1'b1;
    hs_n = h;
    vs_n = v;
    r = p;
    g = p;
    b = p;
    if (cl) begin
      m_crc = m_acc;
      m_acc = 16'hFFFF;
    end else if (h & v) m_acc = crc_step(m_acc, {p, p, p});
    mp_vs = v;
    @(negedge clk);
    if (cl) check("frame_start_latency", int'(frame_start), 1);
    dclk = 1'b0;
    repeat (div - 1) @(negedge clk);
  endtask

  task automatic frame(input int short_ln, input int ff_ln, input int ff_px, input int nl);
    for (int ln = 0; ln < nl; ln++)
      for (int p = 0; p < ((ln == short_ln) ? ght - 1 : ght); p++)
        pix(p >= ghs, ln >= gvs, (ln == ff_ln && p == ff_px) ? 8'hFF : 8'h00);
  endtask

  task automatic frames(input int n);
    repeat (n) frame(-1, -1, -1, gvt);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_h_total"}, int'(h_total), ght);
    check({tag, "_h_sync"}, int'(h_sync), ghs);
    check({tag, "_v_total"}, int'(v_total), gvt);
    check({tag, "_v_sync"}, int'(v_sync), gvs);
  endtask

  initial begin
    int fb, mb;
    logic [15:0] c0;
    vecs[0] = '{1, 40, 6, 25, 3, 4, 1};
    vecs[1] = '{1, 40, 6, 25, 3, 3, 0};
    vecs[2] = '{4, 40, 6, 25, 3, 4, 1};
    vecs[3] = '{1, 52, 9, 30, 4, 4, 1};
    vecs[4] = '{2, 33, 1, 12, 1, 5, 1};

    #2;
    check("reset_h_total", int'(h_total), 0);
    check("reset_v_total", int'(v_total), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_frame_start", int'(frame_start), 0);

    for (int i = 0; i < 5; i++) begin
      div = vecs[i].div;
      ght = vecs[i].ht;
      ghs = vecs[i].hsw;
      gvt = vecs[i].vt;
      gvs = vecs[i].vsw;
      do_reset();
      fb = fs_cnt;
      mb = mc_cnt;
      frames(vecs[i].nfr);
      check_meas($sformatf("vec%0d", i));
      check($sformatf("vec%0d_locked", i), int'(locked), vecs[i].lk);
      check($sformatf("vec%0d_fs_pulses", i), fs_cnt - fb, vecs[i].nfr);
      check($sformatf("vec%0d_mc_pulses", i), mc_cnt - mb, 0);
    end

    div = 1;
    ght = 24;
    ghs = 4;
    gvt = 16;
    gvs = 2;

    do_reset();
    frames(4);
    check("short_pre_locked", int'(locked), 1);
    mb = mc_cnt;
    frame(10, -1, -1, gvt);
    frames(1);
    check("short_unlock", int'(locked), 0);
    check("short_mc", mc_cnt - mb, 1);
    check_meas("short");
    frames(2);
    check("short_not_yet", int'(locked), 0);
    frames(1);
    check("short_relock", int'(locked), 1);
    check("short_mc_once", mc_cnt - mb, 1);

    do_reset();
    frames(4);
    mb = mc_cnt;
    repeat (300) pix(1'b1, 1'b1, 8'h00);
    check("wdh_locked", int'(locked), 0);
    check("wdh_mc", mc_cnt - mb, 1);
    check_meas("wdh_hold");
    frames(3);
    check("wdh_not_yet", int'(locked), 0);
    frames(1);
    check("wdh_relock", int'(locked), 1);

    do_reset();
    frames(4);
    mb = mc_cnt;
    for (int ln = 0; ln < 70; ln++)
      for (int p = 0; p < ght; p++) pix(p >= ghs, 1'b1, 8'h00);
    check("wdv_locked", int'(locked), 0);
    check("wdv_mc", mc_cnt - mb, 1);
    check_meas("wdv_hold");

    do_reset();
    frames(4);
    frame(-1, -1, -1, 10);
    check("rst_pre_locked", int'(locked), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_h_total", int'(h_total), 0);
    check("rst_async_h_sync", int'(h_sync), 0);
    check("rst_async_v_total", int'(v_total), 0);
    check("rst_async_v_sync", int'(v_sync), 0);
    check("rst_async_locked", int'(locked), 0);
    check("rst_async_crc", int'(frame_crc), 0);
    @(negedge clk);
    rst = 1'b0;
    mp_vs = 1'b1;
    m_acc = 16'hFFFF;
    m_crc = 16'h0000;
    @(negedge clk);
    frames(3);
    check("rst_not_yet", int'(locked), 0);
    frames(1);
    check("rst_relock", int'(locked), 1);
    check_meas("rst");

`ifdef VIDEO_ANALYZER_CRC_EN
    do_reset();
    frames(2);
    check("crc_f1", int'(frame_crc), int'(m_crc));
    c0 = m_crc;
    frames(1);
    check("crc_f2_model", int'(frame_crc), int'(m_crc));
    check("crc_f2_same", int'(frame_crc == c0), 1);
    frame(-1, 10, 20, gvt);
    frames(1);
    check("crc_f3_model", int'(frame_crc), int'(m_crc));
    check("crc_f3_diff", int'(frame_crc != c0), 1);
    frames(1);
    check("crc_f4_back", int'(frame_crc), int'(c0));
`else
    c0 = 16'h0000;
    check("crc_tied_off", int'(frame_crc), int'(c0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
